// File: rtl/redmule_job_sequencer.sv
// Queues RedMulE GEMM job descriptors and runs them one at a time: program the
// operand/size registers over a req/gnt port, write the trigger, then wait for done.
module redmule_job_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [143:0]             job_i,
    input  logic                     abort_i,
    output logic                     cfg_req_o,
    input  logic                     cfg_gnt_i,
    output logic [7:0]               cfg_addr_o,
    output logic [31:0]              cfg_wdata_o,
    input  logic                     redmule_done_i,
    output logic                     busy_o,
    output logic                     job_done_o,
    output logic                     err_o,
    output logic [CNT_W-1:0]         jobs_done_cnt_o,
    output logic [$clog2(DEPTH):0]   queue_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [2:0]  LAST_IDX = 3'd5;

    typedef enum logic [1:0] {IDLE, CFG, WAIT} state_e;

    state_e             state_q, state_d;
    logic [143:0]       mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]        cnt_q, cnt_d;
    logic [143:0]       job_q, job_d;
    logic [2:0]         idx_q, idx_d;
    logic               cfg_req_q, cfg_req_d;
    logic [7:0]         cfg_addr_q, cfg_addr_d;
    logic [31:0]        cfg_wdata_q, cfg_wdata_d;
    logic               job_done_q, job_done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   jobs_cnt_q, jobs_cnt_d;

    logic               full, push, pop, head_zero;
    logic [143:0]       head;

    // Register image of a job: {addr, data} for write slot i; slot 5 is the trigger.
    function automatic logic [39:0] reg_write(input logic [2:0] i, input logic [143:0] j);
        case (i)
            3'd0:    reg_write = {8'h00, j[31:0]};
            3'd1:    reg_write = {8'h04, j[63:32]};
            3'd2:    reg_write = {8'h08, j[95:64]};
            3'd3:    reg_write = {8'h0C, j[127:96]};
            3'd4:    reg_write = {8'h10, 16'h0, j[143:128]};
            default: reg_write = {8'h18, 32'h0};
        endcase
    endfunction

    always_comb begin
        full      = (cnt_q == FULL_CNT);
        head      = mem_q[rd_ptr_q];
        head_zero = (head[111:96] == 16'd0) || (head[127:112] == 16'd0) || (head[143:128] == 16'd0);
        push      = job_valid_i && !full && !abort_i;
        pop       = (state_q == IDLE) && (cnt_q != '0) && !abort_i;

        if (abort_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end

        state_d     = state_q;
        job_d       = job_q;
        idx_d       = idx_q;
        cfg_req_d   = cfg_req_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        jobs_cnt_d  = jobs_cnt_q;
        job_done_d  = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (head_zero) begin
                        err_d = 1'b1;
                    end else begin
                        state_d                   = CFG;
                        job_d                     = head;
                        idx_d                     = 3'd0;
                        cfg_req_d                 = 1'b1;
                        {cfg_addr_d, cfg_wdata_d} = reg_write(3'd0, head);
                    end
                end
            end
            CFG: begin
                // Abort wins over a grant arriving in the same cycle.
                if (abort_i) begin
                    state_d   = IDLE;
                    cfg_req_d = 1'b0;
                end else if (cfg_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = WAIT;
                        cfg_req_d = 1'b0;
                    end else begin
                        idx_d                     = idx_q + 3'd1;
                        {cfg_addr_d, cfg_wdata_d} = reg_write(idx_q + 3'd1, job_q);
                    end
                end
            end
            WAIT: begin
                if (redmule_done_i) begin
                    state_d    = IDLE;
                    job_done_d = 1'b1;
                    jobs_cnt_d = jobs_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (redmule_done_i && (state_q != WAIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= job_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            job_q       <= '0;
            idx_q       <= '0;
            cfg_req_q   <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            job_done_q  <= 1'b0;
            err_q       <= 1'b0;
            jobs_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            job_q       <= job_d;
            idx_q       <= idx_d;
            cfg_req_q   <= cfg_req_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            job_done_q  <= job_done_d;
            err_q       <= err_d;
            jobs_cnt_q  <= jobs_cnt_d;
        end
    end

    assign job_ready_o     = !full;
    assign cfg_req_o       = cfg_req_q;
    assign cfg_addr_o      = cfg_addr_q;
    assign cfg_wdata_o     = cfg_wdata_q;
    assign busy_o          = (state_q != IDLE) || (cnt_q != '0);
    assign job_done_o      = job_done_q;
    assign err_o           = err_q;
    assign jobs_done_cnt_o = jobs_cnt_q;
    assign queue_cnt_o     = cnt_q;

endmodule

// File: tb/tb_redmule_job_sequencer.sv
// Directed bench for redmule_job_sequencer; a 4-bit completion counter keeps the
// wrap-around case within a short run.
module tb_redmule_job_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               job_valid = 1'b0;
    logic               job_ready;
    logic [143:0]       job_data = '0;
    logic               abort = 1'b0;
    logic               cfg_req;
    logic               cfg_gnt = 1'b1;
    logic [7:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic               done = 1'b0;
    logic               busy;
    logic               job_done;
    logic               err;
    logic [CNT_W-1:0]   jobs_cnt;
    logic [2:0]         queue_cnt;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int trig_cnt = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    redmule_job_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_i(job_data),
        .abort_i(abort),
        .cfg_req_o(cfg_req), .cfg_gnt_i(cfg_gnt), .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata),
        .redmule_done_i(done),
        .busy_o(busy), .job_done_o(job_done), .err_o(err),
        .jobs_done_cnt_o(jobs_cnt), .queue_cnt_o(queue_cnt)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer of granted writes and output pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_req && cfg_gnt) begin
                wr_cnt++;
                if (cfg_addr == 8'h18) trig_cnt++;
            end
            if (job_done) done_pulses++;
            if (err) err_pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [143:0] mk_job(input logic [31:0] x, input logic [31:0] w,
                                            input logic [31:0] z, input logic [15:0] m,
                                            input logic [15:0] n, input logic [15:0] k);
        return {k, n, m, z, w, x};
    endfunction

    // Move to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_trig(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (trig_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic run_job(input logic [143:0] j, output bit ok);
        int tgt;
        tgt = trig_cnt + 1;
        step();
        job_valid = 1'b1;
        job_data  = j;
        step();
        job_valid = 1'b0;
        wait_trig(tgt, ok);
        pulse_done();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (cfg_req !== 1'b0)  begin errors++; $display("FAIL reset_req got=%b exp=0", cfg_req); end
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", job_ready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (jobs_cnt !== '0)   begin errors++; $display("FAIL reset_cnt got=%0d exp=0", jobs_cnt); end
        checks++; if (queue_cnt !== 3'd0 || job_done !== 1'b0 || err !== 1'b0 || cfg_addr !== 8'h00 || cfg_wdata !== 32'h0)
            begin errors++; $display("FAIL reset_misc qcnt=%0d done=%b err=%b addr=%h data=%h exp all 0", queue_cnt, job_done, err, cfg_addr, cfg_wdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0]  ea;
        logic [31:0] ed;
        step();
        job_valid = 1'b1;
        job_data  = mk_job(32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd8, 16'd16);
        step();
        job_valid = 1'b0;
        checks++; if (queue_cnt !== 3'd1 || cfg_req !== 1'b0)
            begin errors++; $display("FAIL single_t1 qcnt=%0d req=%b exp 1/0", queue_cnt, cfg_req); end
        for (int i = 0; i < 6; i++) begin
            step();
            case (i)
                0: begin ea = 8'h00; ed = 32'h0000_1000; end
                1: begin ea = 8'h04; ed = 32'h0000_2000; end
                2: begin ea = 8'h08; ed = 32'h0000_3000; end
                3: begin ea = 8'h0C; ed = 32'h0008_0004; end
                4: begin ea = 8'h10; ed = 32'h0000_0010; end
                default: begin ea = 8'h18; ed = 32'h0; end
            endcase
            checks++; if (cfg_req !== 1'b1 || cfg_addr !== ea || cfg_wdata !== ed)
                begin errors++; $display("FAIL single_write%0d req=%b addr=%h data=%h exp 1/%h/%h", i, cfg_req, cfg_addr, cfg_wdata, ea, ed); end
        end
        step();
        checks++; if (cfg_req !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL single_wait req=%b busy=%b exp 0/1", cfg_req, busy); end
        repeat (12) step();
        done = 1'b1;
        checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL single_early_done got=%b exp=0", job_done); end
        step();
        done = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (job_done !== 1'b1 || jobs_cnt !== exp_cnt)
            begin errors++; $display("FAIL single_done done=%b cnt=%0d exp 1/%0d", job_done, jobs_cnt, exp_cnt); end
        step();
        checks++; if (job_done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL single_idle done=%b busy=%b exp 0/0", job_done, busy); end
    endtask

    task automatic test_gnt_stall();
        logic [7:0]  ea;
        logic [31:0] ed;
        logic        g;
        bit          ok;
        step();
        job_valid = 1'b1;
        job_data  = mk_job(32'hA0, 32'hB0, 32'hC0, 16'd2, 16'd3, 16'd5);
        step();
        job_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            case (c)
                0: begin ea = 8'h00; ed = 32'hA0; g = 1'b1; end
                1: begin ea = 8'h04; ed = 32'hB0; g = 1'b1; end
                2, 3, 4: begin ea = 8'h08; ed = 32'hC0; g = 1'b0; end
                5: begin ea = 8'h08; ed = 32'hC0; g = 1'b1; end
                6: begin ea = 8'h0C; ed = 32'h0003_0002; g = 1'b1; end
                7: begin ea = 8'h10; ed = 32'h5; g = 1'b1; end
                default: begin ea = 8'h18; ed = 32'h0; g = 1'b1; end
            endcase
            cfg_gnt = g;
            checks++; if (cfg_req !== 1'b1 || cfg_addr !== ea || cfg_wdata !== ed)
                begin errors++; $display("FAIL stall_cycle%0d req=%b addr=%h data=%h exp 1/%h/%h", c, cfg_req, cfg_addr, cfg_wdata, ea, ed); end
        end
        cfg_gnt = 1'b1;
        step();
        checks++; if (cfg_req !== 1'b0) begin errors++; $display("FAIL stall_req_drop got=%b exp=0", cfg_req); end
        pulse_done();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (job_done !== 1'b1 || jobs_cnt !== exp_cnt)
            begin errors++; $display("FAIL stall_done done=%b cnt=%0d exp 1/%0d", job_done, jobs_cnt, exp_cnt); end
        ok = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int  base_trig, base_done;
        bit  ok;
        base_trig = trig_cnt;
        base_done = done_pulses;
        for (int j = 0; j < 5; j++) begin
            step();
            checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", j, job_ready); end
            job_valid = 1'b1;
            job_data  = mk_job(32'h100 * (j + 1), 32'h44, 32'h88, 16'd1, 16'd1, 16'(j + 1));
        end
        step();
        job_data = mk_job(32'hDEAD, 32'h1, 32'h2, 16'd1, 16'd1, 16'd1);
        checks++; if (job_ready !== 1'b0 || queue_cnt !== 3'd4)
            begin errors++; $display("FAIL b2b_full ready=%b qcnt=%0d exp 0/4", job_ready, queue_cnt); end
        step();
        step();
        job_valid = 1'b0;
        checks++; if (queue_cnt !== 3'd4) begin errors++; $display("FAIL b2b_no_push qcnt=%0d exp=4", queue_cnt); end
        for (int j = 0; j < 5; j++) begin
            wait_trig(base_trig + j + 1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_trig%0d timeout trig=%0d exp=%0d", j, trig_cnt, base_trig + j + 1); end
            if (j == 4) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last got=%b exp=1", busy); end
            end
            pulse_done();
        end
        step();
        exp_cnt = exp_cnt + 4'd5;
        checks++; if (done_pulses - base_done !== 5 || jobs_cnt !== exp_cnt || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_end pulses=%0d cnt=%0d busy=%b exp 5/%0d/0", done_pulses - base_done, jobs_cnt, busy, exp_cnt); end
    endtask

    task automatic test_zero_size();
        int w0, e0;
        bit ok;
        w0 = wr_cnt;
        e0 = err_pulses;
        step();
        job_valid = 1'b1;
        job_data  = mk_job(32'h1, 32'h2, 32'h3, 16'd4, 16'd4, 16'd0);
        step();
        job_valid = 1'b0;
        step();
        checks++; if (err !== 1'b1 || cfg_req !== 1'b0)
            begin errors++; $display("FAIL zero_err err=%b req=%b exp 1/0", err, cfg_req); end
        step();
        checks++; if (err !== 1'b0 || cfg_req !== 1'b0 || queue_cnt !== 3'd0 || wr_cnt !== w0 || jobs_cnt !== exp_cnt)
            begin errors++; $display("FAIL zero_after err=%b req=%b qcnt=%0d writes=%0d cnt=%0d exp 0/0/0/%0d/%0d", err, cfg_req, queue_cnt, wr_cnt, jobs_cnt, w0, exp_cnt); end
        run_job(mk_job(32'h10, 32'h20, 32'h30, 16'd1, 16'd2, 16'd3), ok);
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (!ok || jobs_cnt !== exp_cnt || wr_cnt !== w0 + 6 || err_pulses !== e0 + 1)
            begin errors++; $display("FAIL zero_next ok=%b cnt=%0d writes=%0d errs=%0d exp 1/%0d/%0d/%0d", ok, jobs_cnt, wr_cnt, err_pulses, exp_cnt, w0 + 6, e0 + 1); end
    endtask

    task automatic test_abort();
        int d0, e0, w1, tgt;
        bit ok;
        d0 = done_pulses;
        e0 = err_pulses;
        for (int j = 0; j < 3; j++) begin
            step();
            job_valid = 1'b1;
            job_data  = mk_job(32'h500 + j, 32'h600, 32'h700, 16'd2, 16'd2, 16'd2);
        end
        step();
        job_valid = 1'b0;
        checks++; if (queue_cnt !== 3'd2) begin errors++; $display("FAIL abort_qcnt_pre got=%0d exp=2", queue_cnt); end
        step();
        checks++; if (cfg_req !== 1'b1 || cfg_addr !== 8'h08)
            begin errors++; $display("FAIL abort_idx2 req=%b addr=%h exp 1/08", cfg_req, cfg_addr); end
        abort     = 1'b1;
        job_valid = 1'b1;
        job_data  = mk_job(32'hBAD, 32'h1, 32'h1, 16'd1, 16'd1, 16'd1);
        step();
        abort     = 1'b0;
        job_valid = 1'b0;
        w1 = wr_cnt;
        checks++; if (cfg_req !== 1'b0 || queue_cnt !== 3'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL abort_cfg req=%b qcnt=%0d busy=%b exp 0/0/0", cfg_req, queue_cnt, busy); end
        repeat (6) step();
        checks++; if (done_pulses !== d0 || err_pulses !== e0 || wr_cnt !== w1 || jobs_cnt !== exp_cnt)
            begin errors++; $display("FAIL abort_quiet pulses=%0d errs=%0d writes=%0d cnt=%0d exp %0d/%0d/%0d/%0d", done_pulses, err_pulses, wr_cnt, jobs_cnt, d0, e0, w1, exp_cnt); end
        tgt = trig_cnt + 1;
        step();
        job_valid = 1'b1;
        job_data  = mk_job(32'h900, 32'hA00, 32'hB00, 16'd3, 16'd3, 16'd3);
        step();
        job_valid = 1'b0;
        wait_trig(tgt, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_wait_trig timeout trig=%0d exp=%0d", trig_cnt, tgt); end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_wait_busy got=%b exp=1", busy); end
        pulse_done();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (job_done !== 1'b1 || jobs_cnt !== exp_cnt)
            begin errors++; $display("FAIL abort_wait_done done=%b cnt=%0d exp 1/%0d", job_done, jobs_cnt, exp_cnt); end
        step();
    endtask

    task automatic test_spurious_and_wrap();
        bit ok;
        int n;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (err !== 1'b1 || jobs_cnt !== exp_cnt || job_done !== 1'b0)
            begin errors++; $display("FAIL spurious err=%b cnt=%0d done=%b exp 1/%0d/0", err, jobs_cnt, job_done, exp_cnt); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL spurious_clear got=%b exp=0", err); end
        n = 0;
        while (exp_cnt != 4'hF && n < 20) begin
            run_job(mk_job(32'h40, 32'h50, 32'h60, 16'd1, 16'd1, 16'd1), ok);
            exp_cnt = exp_cnt + 1'b1;
            n++;
            checks++; if (!ok) begin errors++; $display("FAIL wrap_fill timeout job=%0d", n); end
        end
        checks++; if (jobs_cnt !== 4'hF) begin errors++; $display("FAIL wrap_max got=%0d exp=15", jobs_cnt); end
        run_job(mk_job(32'h41, 32'h51, 32'h61, 16'd1, 16'd1, 16'd1), ok);
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (!ok || jobs_cnt !== 4'h0)
            begin errors++; $display("FAIL wrap ok=%b cnt=%0d exp 1/0", ok, jobs_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gnt_stall();
        test_back_to_back();
        test_zero_size();
        test_abort();
        test_spurious_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
